// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential instruction-fetch front end. Holds the PC, fetches one 32-bit
// instruction at a time over a req/ack memory port, presents it for a single
// EXEC cycle (decode feeds the control unit), then advances the PC
// sequentially or by a branch offset, or halts.
//
// Ports:
//   CLK, Reset         clock; synchronous active-high reset
//   imem_req/addr      fetch request (held until ack) and byte address (= pc)
//   imem_rdata/ack     instruction word and one-cycle completion strobe
//   instr, decode      last fetched instruction and its opcode field [31:26]
//   instr_valid        high during the single EXEC cycle
//   PCWre, PCSrc,      control-unit outputs, sampled in EXEC only:
//   InsMemRW             PCWre=0 or InsMemRW=0 halts, PCSrc=1 takes branch
//   pc                 current program counter
//   halted, fetch_err  sticky status flags, cleared only by Reset
//   instr_count        number of completed EXEC cycles (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic [31:0]      instr,
    output logic [5:0]       decode,
    output logic             instr_valid,
    input  logic             PCWre,
    input  logic             PCSrc,
    input  logic             InsMemRW,
    output logic [31:0]      pc,
    output logic             halted,
    output logic             fetch_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALT
    } state_t;

    // Last wait-counter value tolerated before the fetch is declared lost.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q,     state_d;
    logic [31:0]      pc_q,        pc_d;
    logic [31:0]      instr_q,     instr_d;
    logic [7:0]       wait_cnt_q,  wait_cnt_d;
    logic             halted_q,    halted_d;
    logic             fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic [31:0]      branch_off;

    // Word offset from instr[15:0], sign-extended and scaled to bytes.
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        wait_cnt_d  = wait_cnt_q;
        halted_d    = halted_q;
        fetch_err_d = fetch_err_q;
        count_d     = count_q;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = 8'd0;
                    state_d    = S_EXEC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    halted_d    = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_EXEC: begin
                count_d = count_q + CNT_W'(1);
                if (!PCWre || !InsMemRW) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = PCSrc ? (pc_q + 32'd4 + branch_off) : (pc_q + 32'd4);
                    state_d = S_REQ;
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            instr_q     <= 32'd0;
            wait_cnt_q  <= 8'd0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
            count_q     <= count_d;
        end
    end

    // Request and valid are pure state decodes, so a reset edge drops the
    // request immediately and acks outside REQ have no effect.
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_EXEC);
    assign instr       = instr_q;
    assign decode      = instr_q[31:26];
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A small instruction memory answers
// requests after a programmable delay; a tiny control-unit model derives
// PCWre/InsMemRW/PCSrc from decode (opcode 3F halts, opcode 04 branches
// when take_br is set).
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [5:0]  decode;
    logic        instr_valid;
    logic        PCWre;
    logic        PCSrc;
    logic        InsMemRW;
    logic [31:0] pc;
    logic        halted;
    logic        fetch_err;
    logic [31:0] instr_count;

    logic [31:0] mem [0:15];
    int          ack_delay;
    logic        ack_en;
    logic        force_ack;
    logic        take_br;
    int          req_cycles;

    int total;
    int bad;

    instr_fetch_unit #(
        .PC_RESET(32'h0000_0000),
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .decode     (decode),
        .instr_valid(instr_valid),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .InsMemRW   (InsMemRW),
        .pc         (pc),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .instr_count(instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control-unit model.
    assign PCWre    = (decode != 6'h3F);
    assign InsMemRW = (decode != 6'h3F);
    assign PCSrc    = (decode == 6'h04) && take_br;

    // Memory model: rdata is garbage except in the ack cycle.
    always @(posedge CLK) req_cycles <= imem_req ? req_cycles + 1 : 0;
    assign imem_ack   = force_ack || (ack_en && imem_req && (req_cycles >= ack_delay));
    assign imem_rdata = imem_ack ? mem[imem_addr[5:2]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    // Advance until a request for addr is on the bus; bounded.
    task automatic run_to(input logic [31:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            if (imem_req && imem_addr == addr) hit = 1'b1;
        end
        check("reach_addr", hit, 1'b1);
    endtask

    initial begin
        logic req_seen;
        total      = 0;
        bad        = 0;
        req_cycles = 0;
        ack_delay  = 0;
        ack_en     = 1'b1;
        force_ack  = 1'b0;
        take_br    = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);  // opcode 000000
        mem[8]  = 32'h1000_FFFE;                           // opcode 04, imm -2
        mem[9]  = 32'hFC00_0000;                           // opcode 3F, halt
        for (int i = 10; i < 16; i++) mem[i] = 32'h0;

        // ---- reset state and sequential fetch, zero-wait ack ----
        do_reset();
        check("rst_pc",     pc,          32'h0);
        check("rst_req",    imem_req,    1'b0);
        check("rst_instr",  instr,       32'h0);
        check("rst_decode", decode,      6'h0);
        check("rst_valid",  instr_valid, 1'b0);
        check("rst_halted", halted,      1'b0);
        check("rst_ferr",   fetch_err,   1'b0);
        check("rst_count",  instr_count, 32'h0);
        step();
        check("seq_req0",   imem_req,    1'b1);
        check("seq_addr0",  imem_addr,   32'h0);
        step();
        check("seq_valid0", instr_valid, 1'b1);
        check("seq_instr0", instr,       32'h1);
        check("seq_noreq",  imem_req,    1'b0);
        step();
        check("seq_addr1",  imem_addr,   32'h4);
        check("seq_cnt1",   instr_count, 32'd1);
        check("seq_novld",  instr_valid, 1'b0);
        step();
        check("seq_valid1", instr_valid, 1'b1);
        step();
        check("seq_addr2",  imem_addr,   32'h8);
        step();
        check("seq_instr2", instr,       32'h3);
        step();
        check("seq_addr3",  imem_addr,   32'hC);
        check("seq_cnt3",   instr_count, 32'd3);

        // ---- delayed ack: request held 4 cycles at a stable address ----
        ack_delay = 3;
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            check("dly_req",  imem_req,  1'b1);
            check("dly_addr", imem_addr, 32'h0);
            if (i < 3) step();
        end
        step();
        check("dly_exec",  instr_valid, 1'b1);
        check("dly_instr", instr,       32'h1);
        check("dly_drop",  imem_req,    1'b0);
        ack_delay = 0;

        // ---- backward branch taken at 0x20 ----
        take_br = 1'b1;
        do_reset();
        run_to(32'h20);
        step();
        check("br_decode", decode, 6'h04);
        step();
        check("br_taken",  imem_addr, 32'h1C);

        // ---- same instruction, branch not taken, then halt at 0x24 ----
        take_br = 1'b0;
        do_reset();
        run_to(32'h20);
        step();
        step();
        check("br_nottaken", imem_addr, 32'h24);
        step();
        check("halt_decode", decode, 6'h3F);
        check("halt_valid",  instr_valid, 1'b1);
        step();
        check("halt_flag",   halted,      1'b1);
        check("halt_ferr",   fetch_err,   1'b0);
        check("halt_count",  instr_count, 32'd10);
        force_ack = 1'b1;
        req_seen  = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (imem_req || instr_valid) req_seen = 1'b1;
        end
        force_ack = 1'b0;
        check("halt_quiet",  req_seen,    1'b0);
        check("halt_pc",     pc,          32'h24);
        check("halt_instr",  instr,       32'hFC00_0000);
        check("halt_count2", instr_count, 32'd10);

        // ---- fetch timeout: no ack, error 16 cycles after req rises ----
        ack_en = 1'b0;
        do_reset();
        step();
        check("to_req", imem_req, 1'b1);
        for (int i = 0; i < 15; i++) step();
        check("to_early",  fetch_err, 1'b0);
        check("to_hold",   imem_req,  1'b1);
        step();
        check("to_ferr",   fetch_err, 1'b1);
        check("to_halted", halted,    1'b1);
        check("to_noreq",  imem_req,  1'b0);
        step();
        check("to_sticky", fetch_err, 1'b1);

        // ---- reset mid-fetch with a simultaneous ack ----
        ack_en = 1'b1;
        do_reset();
        step();
        step();
        step();
        check("mr_addr", imem_addr,   32'h4);
        check("mr_cnt",  instr_count, 32'd1);
        ack_en = 1'b0;
        step();
        step();
        Reset     = 1'b1;
        force_ack = 1'b1;
        step();
        check("mr_pc",    pc,          32'h0);
        check("mr_req",   imem_req,    1'b0);
        check("mr_instr", instr,       32'h0);
        check("mr_cnt0",  instr_count, 32'h0);
        check("mr_ferr",  fetch_err,   1'b0);
        Reset     = 1'b0;
        force_ack = 1'b0;
        ack_en    = 1'b1;
        check("mr_idle",  imem_req,    1'b0);
        step();
        check("mr_restart_req",  imem_req,  1'b1);
        check("mr_restart_addr", imem_addr, 32'h0);
        step();
        check("mr_restart_instr", instr, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential instruction-fetch front end that drives the opcode into the control unit and acts on the control unit's PC-side outputs.
- Control-unit inputs consumed: PCWre, PCSrc, InsMemRW.
- Holds the PC and fetches 32-bit instructions over a req/ack instruction-memory port.
- Presents each instruction for one execute cycle, then advances the PC (sequential or branch), or halts.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.
- TIMEOUT, 16, max cycles to wait for imem_ack before a fetch error; legal range 1..255.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high reset.
- imem_req, output, 1, fetch request; held until ack.
- imem_addr, output, 32, byte address of the fetch; equals pc.
- imem_rdata, input, 32, instruction word; valid only when imem_ack=1.
- imem_ack, input, 1, one-cycle completion strobe from instruction memory.
- instr, output, 32, last fetched instruction.
- decode, output, 6, instr[31:26]; feeds the control unit opcode input.
- instr_valid, output, 1, high during the single EXEC cycle.
- PCWre, input, 1, from control unit; 0 means halt.
- PCSrc, input, 1, from control unit; 1 means take branch.
- InsMemRW, input, 1, from control unit; 0 means stop fetching (halt).
- pc, output, 32, current program counter.
- halted, output, 1, sticky halt flag.
- fetch_err, output, 1, sticky; set on ack timeout.
- instr_count, output, CNT_W, number of EXEC cycles completed.

Behaviour:
- Reset values: pc=PC_RESET, state=IDLE, imem_req=0, instr=0, decode=0, instr_valid=0, halted=0, fetch_err=0, instr_count=0, wait counter=0.
- Reset has priority over every other event. Reset asserted mid-fetch abandons the request: imem_req=0 after that edge, and any ack in the same cycle is ignored.
- IDLE: one cycle, then go to REQ.
- REQ:
  - imem_req=1, imem_addr=pc; wait counter increments each cycle.
  - imem_ack=1: instr<=imem_rdata, wait counter cleared, go to EXEC. An ack in the first REQ cycle is legal (zero-wait fetch).
  - Otherwise, wait counter reaching TIMEOUT-1 with no ack: fetch_err<=1, halted<=1, go to HALT.
- EXEC:
  - Exactly one cycle: instr_valid=1, imem_req=0.
  - Control inputs are sampled this cycle only; the control unit is combinational from decode and settles within the cycle.
  - instr_count increments and wraps modulo 2^CNT_W.
  - PCWre=0 or InsMemRW=0: halted<=1, pc unchanged, go to HALT.
  - Else PCSrc=1: pc <= pc + 4 + (sign_extend(instr[15:0]) << 2).
  - Else: pc <= pc + 4.
  - Then go to REQ.
- HALT: terminal until Reset. imem_req=0, instr_valid=0, pc and instr frozen.
- Arithmetic: all PC math is 32-bit unsigned and wraps modulo 2^32 (e.g. 32'hFFFF_FFFC + 4 = 0). pc[1:0] stays 0 by construction.
- imem_ack seen while imem_req=0 (IDLE, EXEC, HALT): ignored, with no state change.
- decode is a combinational slice of the registered instr, so it changes only on the edge that enters EXEC.
- fetch_err and halted clear only on Reset.

Test Plan:
- Reset, then ack every cycle with instrs at 0x0/0x4/0x8 having opcode 000000, PCWre=1, PCSrc=0 -> imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle after IDLE; instr_count=3 after the third EXEC.
- ack delayed 3 cycles after req -> imem_req held high for exactly 4 cycles at a stable address; instr captured equals imem_rdata from the ack cycle.
- EXEC at pc=0x20 with instr[15:0]=16'hFFFE and PCSrc=1 -> next imem_addr=0x1C. Same instr with PCSrc=0 -> 0x24.
- Opcode 111111 driving PCWre=0, InsMemRW=0 -> halted=1 the next cycle; imem_req stays 0 for 20+ cycles; pc frozen; later acks ignored.
- No ack with TIMEOUT=16 -> fetch_err=1 and halted=1 exactly 16 cycles after req first rises; imem_req=0 afterwards.
- Reset asserted during REQ wait, with ack in the same cycle -> next cycle pc=PC_RESET, state IDLE, instr=0, instr_count=0; fetch restarts at PC_RESET.
